// File: rtl/triple_counter_seq.sv
// triple_counter_seq: run sequencer for one mod-3 triple_counter.
// Accepts a burst request, clears the counter, issues LEN increment enables
// (with pause/abort), then pulses done and reports how many 2->0 wraps occurred.
// Optional self-check: define TRIPLE_SEQ_CHECK_EN to build a shadow mod-3 model
// that raises a sticky err when the observed count diverges from it.
module triple_counter_seq #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             pause,
  input  logic             abort,
  input  logic [1:0]       count,
  output logic             cnt_clr,
  output logic             cnt_en,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] wraps,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [LEN_W-1:0] ONE       = LEN_W'(1);
  localparam logic [LEN_W-1:0] ZERO      = '0;
  localparam logic [LEN_W-1:0] WRAPS_MAX = '1;

  state_t           state_reg;
  logic [LEN_W-1:0] remaining_reg;
  logic             start_accept;

  // A start only counts when the sequencer is idle; busy/DONE starts are dropped.
  assign start_accept = (state_reg == IDLE) && start;

  // Increment enable is combinational so abort/pause act in the same cycle;
  // abort has priority over pause, pause over the enable itself.
  assign cnt_en = (state_reg == RUN) & ~pause & ~abort;

  // Main FSM with registered cnt_clr/busy/done, burst countdown and wrap counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      remaining_reg <= ZERO;
      wraps         <= ZERO;
      cnt_clr       <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      cnt_clr <= 1'b0;
      done    <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            wraps <= ZERO;
            if (len != ZERO) begin
              state_reg     <= CLEAR;
              remaining_reg <= len;
              cnt_clr       <= 1'b1;
              busy          <= 1'b1;
            end else begin
              // Empty burst: skip the counter entirely and report completion.
              state_reg <= DONE;
              done      <= 1'b1;
              busy      <= 1'b0;
            end
          end
        end
        CLEAR: begin
          if (abort) begin
            state_reg <= IDLE;
            busy      <= 1'b0;
          end else begin
            state_reg <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            state_reg <= IDLE;
            busy      <= 1'b0;
          end else if (cnt_en) begin
            remaining_reg <= remaining_reg - ONE;
            // The counter is at 2 and about to step to 0: that is one wrap.
            if ((count == 2'd2) && (wraps != WRAPS_MAX)) begin
              wraps <= wraps + ONE;
            end
            if (remaining_reg == ONE) begin
              state_reg <= DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
            end
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

`ifdef TRIPLE_SEQ_CHECK_EN
  logic [1:0] exp_reg;

  // Shadow mod-3 model of the counter: follows cnt_clr and cnt_en exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_reg <= 2'd0;
    end else if (state_reg == CLEAR) begin
      exp_reg <= 2'd0;
    end else if (cnt_en) begin
      exp_reg <= (exp_reg == 2'd2) ? 2'd0 : exp_reg + 2'd1;
    end
  end

  // Sticky mismatch flag: set on any RUN-cycle divergence, cleared by a new accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (start_accept) begin
      err <= 1'b0;
    end else if ((state_reg == RUN) && ((count != exp_reg) || (count == 2'd3))) begin
      err <= 1'b1;
    end
  end
`else
  logic unused_start_accept;
  assign unused_start_accept = start_accept;
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_triple_counter_seq.sv
// Testbench for triple_counter_seq with a behavioural mod-3 counter attached.
// Expected burst results are pushed to scoreboard queues when a burst is
// launched and popped/compared once the burst window has been observed.
module tb_triple_counter_seq;

  localparam int LEN_W = 8;
`ifdef TRIPLE_SEQ_CHECK_EN
  localparam int CHECK = 1;
`else
  localparam int CHECK = 0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic             pause = 1'b0;
  logic             abort = 1'b0;
  logic [1:0]       count;
  logic             cnt_clr, cnt_en, busy, done, err;
  logic [LEN_W-1:0] wraps;

  triple_counter_seq #(.LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .pause(pause), .abort(abort),
    .count(count), .cnt_clr(cnt_clr), .cnt_en(cnt_en), .busy(busy), .done(done),
    .wraps(wraps), .err(err)
  );

  always #5 clk = ~clk;

  // Behavioural triple_counter; force_en injects an illegal value of 3.
  logic [1:0] ctr = 2'd0;
  logic       force_en = 1'b0;
  always @(posedge clk) begin
    if (cnt_clr) ctr <= 2'd0;
    else if (cnt_en) ctr <= (ctr == 2'd2) ? 2'd0 : ctr + 2'd1;
  end
  assign count = force_en ? 2'd3 : ctr;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    int n_en; int wraps; int fin; int done_lat;
  } exp_t;

  typedef struct packed {
    int n_clr; int clr_lat; int n_en; int first_en; int last_en; int n_done;
    int done_lat; int busy_end; int wraps_end; int err_end; int count_end;
    int abort_lat; int busy_post;
  } obs_t;

  exp_t exp_q[$];
  int   cnt_exp_q[$];
  int   seen_q[$];

  // Scoreboard model: step an ideal mod-3 counter L times from 0.
  task automatic predict(input int L, input int pcyc);
    exp_t e;
    int c, w;
    c = 0; w = 0;
    for (int i = 0; i < L; i++) begin
      cnt_exp_q.push_back(c);
      if (c == 2) begin w++; c = 0; end
      else c++;
    end
    e.n_en = L; e.wraps = w; e.fin = c;
    e.done_lat = (L == 0) ? 1 : 2 + L + pcyc;
    exp_q.push_back(e);
  endtask

  // Launch one burst and observe a fixed window of cycles (no comparisons here).
  task automatic drive_burst(input int L, input int pause_after, input int pcyc,
                             input int abort_on, input int restart_lat,
                             input int force_lat, output obs_t o);
    int en_idx, pl;
    o = '0;
    o.busy_post = 1;
    en_idx = 0; pl = 0;
    seen_q.delete();
    @(posedge clk); #1;
    start = 1'b1; len = 8'(L);
    @(posedge clk); #1;
    start = 1'b0;
    for (int lat = 1; lat <= L + pcyc + 6; lat++) begin
      start = (lat == restart_lat);
      if (lat == restart_lat) len = 8'd9;
      force_en = (lat == force_lat);
      pause = 1'b0; abort = 1'b0;
      if (busy && !cnt_clr) begin
        if (pl > 0) begin pause = 1'b1; pl--; end
        else if (abort_on == en_idx + 1) begin abort = 1'b1; o.abort_lat = lat; end
      end
      @(negedge clk);
      if (cnt_clr) begin o.n_clr++; o.clr_lat = lat; end
      if (cnt_en) begin
        en_idx++;
        seen_q.push_back(int'(count));
        if (o.first_en == 0) o.first_en = lat;
        o.last_en = lat;
        if (en_idx == pause_after) pl = pcyc;
      end
      if (done) begin o.n_done++; o.done_lat = lat; end
      if (o.abort_lat != 0 && lat == o.abort_lat + 1) o.busy_post = int'(busy);
      o.busy_end = int'(busy); o.wraps_end = int'(wraps);
      o.err_end = int'(err); o.count_end = int'(count);
      @(posedge clk); #1;
    end
    start = 1'b0; pause = 1'b0; abort = 1'b0; force_en = 1'b0;
    o.n_en = en_idx;
    $display("burst len=%0d clr=%0d en=%0d done=%0d@%0d wraps=%0d count=%0d err=%0d",
             L, o.n_clr, o.n_en, o.n_done, o.done_lat, o.wraps_end, o.count_end, o.err_end);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({cnt_clr, cnt_en, busy, done, err} !== 5'b0) begin
      n_bad++; $display("FAIL reset_flags: got %b expected 00000", {cnt_clr, cnt_en, busy, done, err});
    end
    n_cmp++;
    if (wraps !== 8'd0) begin n_bad++; $display("FAIL reset_wraps: got %0d expected 0", wraps); end
    @(posedge clk); #1;
    rst = 1'b0;
    $display("reset released");
  endtask

  task automatic test_reset_mid_run();
    int n_ev;
    @(posedge clk); #1;
    start = 1'b1; len = 8'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (wraps !== 8'd1) begin n_bad++; $display("FAIL midrun_wraps_before: got %0d expected 1", wraps); end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({cnt_clr, cnt_en, busy, done, err} !== 5'b0 || wraps !== 8'd0) begin
      n_bad++;
      $display("FAIL midrun_reset: got flags %b wraps %0d expected 00000 / 0",
               {cnt_clr, cnt_en, busy, done, err}, wraps);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    n_ev = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || cnt_en || cnt_clr || busy) n_ev++;
    end
    n_cmp++;
    if (n_ev != 0) begin n_bad++; $display("FAIL midrun_idle_after: got %0d active cycles expected 0", n_ev); end
    $display("reset mid-run len=9 checked");
  endtask

  task automatic test_burst();
    obs_t o; exp_t e; int ec, sc;
    predict(5, 0);
    drive_burst(5, 0, 0, 0, 0, 0, o);
    e = exp_q.pop_front();
    n_cmp++;
    if (o.n_clr != 1 || o.clr_lat != 1) begin
      n_bad++; $display("FAIL burst_clr: got %0d@%0d expected 1@1", o.n_clr, o.clr_lat);
    end
    n_cmp++;
    if (o.n_en != e.n_en || o.first_en != 2 || o.last_en - o.first_en + 1 != e.n_en) begin
      n_bad++; $display("FAIL burst_en: got %0d in lat %0d..%0d expected %0d from 2 consecutive",
                        o.n_en, o.first_en, o.last_en, e.n_en);
    end
    while (cnt_exp_q.size() > 0) begin
      ec = cnt_exp_q.pop_front();
      sc = (seen_q.size() > 0) ? seen_q.pop_front() : -1;
      n_cmp++;
      if (sc !== ec) begin n_bad++; $display("FAIL burst_count_seq: got %0d expected %0d", sc, ec); end
    end
    n_cmp++;
    if (o.n_done != 1 || o.done_lat != e.done_lat) begin
      n_bad++; $display("FAIL burst_done: got %0d@%0d expected 1@%0d", o.n_done, o.done_lat, e.done_lat);
    end
    n_cmp++;
    if (o.wraps_end != e.wraps) begin n_bad++; $display("FAIL burst_wraps: got %0d expected %0d", o.wraps_end, e.wraps); end
    n_cmp++;
    if (o.count_end != e.fin) begin n_bad++; $display("FAIL burst_final: got %0d expected %0d", o.count_end, e.fin); end
  endtask

  task automatic test_pause();
    obs_t o; exp_t e; int ec, sc;
    predict(6, 3);
    drive_burst(6, 2, 3, 0, 0, 0, o);
    e = exp_q.pop_front();
    while (cnt_exp_q.size() > 0) begin
      ec = cnt_exp_q.pop_front();
      sc = (seen_q.size() > 0) ? seen_q.pop_front() : -1;
      n_cmp++;
      if (sc !== ec) begin n_bad++; $display("FAIL pause_count_seq: got %0d expected %0d", sc, ec); end
    end
    n_cmp++;
    if (o.n_en != e.n_en) begin n_bad++; $display("FAIL pause_en: got %0d expected %0d", o.n_en, e.n_en); end
    n_cmp++;
    if (o.n_done != 1 || o.done_lat != e.done_lat) begin
      n_bad++; $display("FAIL pause_done: got %0d@%0d expected 1@%0d", o.n_done, o.done_lat, e.done_lat);
    end
    n_cmp++;
    if (o.wraps_end != e.wraps) begin n_bad++; $display("FAIL pause_wraps: got %0d expected %0d", o.wraps_end, e.wraps); end
    n_cmp++;
    if (o.count_end != e.fin) begin n_bad++; $display("FAIL pause_final: got %0d expected %0d", o.count_end, e.fin); end
  endtask

  task automatic test_zero_len();
    obs_t o; exp_t e;
    predict(0, 0);
    drive_burst(0, 0, 0, 0, 0, 0, o);
    e = exp_q.pop_front();
    n_cmp++;
    if (o.n_clr != 0 || o.n_en != 0) begin
      n_bad++; $display("FAIL zero_activity: got clr %0d en %0d expected 0 / 0", o.n_clr, o.n_en);
    end
    n_cmp++;
    if (o.n_done != 1 || o.done_lat != e.done_lat) begin
      n_bad++; $display("FAIL zero_done: got %0d@%0d expected 1@%0d", o.n_done, o.done_lat, e.done_lat);
    end
    n_cmp++;
    if (o.wraps_end != 0) begin n_bad++; $display("FAIL zero_wraps: got %0d expected 0", o.wraps_end); end
  endtask

  task automatic test_start_ignored();
    obs_t o; exp_t e;
    predict(4, 0);
    drive_burst(4, 0, 0, 0, 3, 0, o);
    e = exp_q.pop_front();
    cnt_exp_q.delete();
    n_cmp++;
    if (o.n_clr != 1 || o.n_en != e.n_en || o.n_done != 1 || o.done_lat != e.done_lat) begin
      n_bad++; $display("FAIL busy_restart: got clr %0d en %0d done %0d@%0d expected 1 / %0d / 1@%0d",
                        o.n_clr, o.n_en, o.n_done, o.done_lat, e.n_en, e.done_lat);
    end
    predict(2, 0);
    drive_burst(2, 0, 0, 0, 4, 0, o);
    e = exp_q.pop_front();
    cnt_exp_q.delete();
    n_cmp++;
    if (o.n_clr != 1 || o.n_en != e.n_en || o.n_done != 1) begin
      n_bad++; $display("FAIL done_restart: got clr %0d en %0d done %0d expected 1 / %0d / 1",
                        o.n_clr, o.n_en, o.n_done, e.n_en);
    end
  endtask

  task automatic test_abort();
    obs_t o;
    drive_burst(8, 0, 0, 3, 0, 0, o);
    n_cmp++;
    if (o.n_en != 2) begin n_bad++; $display("FAIL abort_en: got %0d expected 2", o.n_en); end
    n_cmp++;
    if (o.n_done != 0) begin n_bad++; $display("FAIL abort_done: got %0d expected 0", o.n_done); end
    n_cmp++;
    if (o.busy_post != 0 || o.busy_end != 0) begin
      n_bad++; $display("FAIL abort_busy: got %0d/%0d expected 0/0", o.busy_post, o.busy_end);
    end
  endtask

  task automatic test_check();
    obs_t o;
    int exp_err;
    exp_err = CHECK;
    drive_burst(6, 0, 0, 0, 0, 4, o);
    n_cmp++;
    if (o.err_end != exp_err) begin n_bad++; $display("FAIL check_err_set: got %0d expected %0d", o.err_end, exp_err); end
    predict(3, 0);
    drive_burst(3, 0, 0, 0, 0, 0, o);
    void'(exp_q.pop_front());
    cnt_exp_q.delete();
    n_cmp++;
    if (o.err_end != 0) begin n_bad++; $display("FAIL check_err_clear: got %0d expected 0", o.err_end); end
  endtask

  task automatic test_short_bursts();
    obs_t o; exp_t e;
    for (int L = 1; L <= 3; L += 2) begin
      predict(L, 0);
      drive_burst(L, 0, 0, 0, 0, 0, o);
      e = exp_q.pop_front();
      cnt_exp_q.delete();
      n_cmp++;
      if (o.n_en != e.n_en || o.done_lat != e.done_lat || o.wraps_end != e.wraps || o.count_end != e.fin) begin
        n_bad++; $display("FAIL short_len%0d: got en %0d done@%0d wraps %0d count %0d expected %0d/%0d/%0d/%0d",
                          L, o.n_en, o.done_lat, o.wraps_end, o.count_end, e.n_en, e.done_lat, e.wraps, e.fin);
      end
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_run();
    test_burst();
    test_pause();
    test_zero_len();
    test_start_ignored();
    test_abort();
    test_check();
    test_short_bursts();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
